// File: rtl/alu_seq.sv
// Registered EX-stage ALU with iterative signed/unsigned multiply/divide and HI/LO registers.
// Latency: 1 cycle for single-cycle ops, N+1 cycles for MULT/DIV, 2 cycles for divide-by-zero.
// Backpressure: in_ready is low while a multiply/divide iterates; in_valid is ignored then.
module alu_seq #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4:0]     alu_op,
    input  logic [N-1:0]   s,
    input  logic [N-1:0]   t,
    input  logic [SHW-1:0] shamt,
    output logic           out_valid,
    output logic [N-1:0]   out,
    output logic           zero,
    output logic           overflow,
    output logic [N-1:0]   hi,
    output logic [N-1:0]   lo
);
    localparam logic [4:0] OP_SLL  = 5'd0,  OP_SRL  = 5'd1,  OP_SRA  = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_ADDU = 5'd4,  OP_SUB  = 5'd5,  OP_SUBU = 5'd6,  OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8,  OP_XOR  = 5'd9,  OP_NOR  = 5'd10, OP_SLT  = 5'd11;
    localparam logic [4:0] OP_SLTU = 5'd12, OP_MULT = 5'd13, OP_MULTU = 5'd14, OP_DIV = 5'd15;
    localparam logic [4:0] OP_DIVU = 5'd16, OP_MFHI = 5'd17, OP_MFLO = 5'd18;
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state, state_nx;
    logic           accept, finish, is_mul, is_div, illegal;
    logic           sgn, s_neg, t_neg;
    logic [N-1:0]   sum, dif, sc_res;
    logic           sc_ovf;
    logic [2*N-1:0] acc;       // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}
    logic [N-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [SHW-1:0] cnt;
    logic           last, neg_q, neg_r, div_zero, div_ovf;
    logic [N:0]     msum, rsh, rdiff;
    logic [2*N-1:0] acc_step, prod;
    logic [N-1:0]   fin_hi, fin_lo;

    function automatic logic [N-1:0] cond_neg(input logic neg, input logic [N-1:0] x);
        return neg ? -x : x;
    endfunction

    assign is_mul  = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
    assign is_div  = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
    assign illegal = (alu_op > OP_MFLO);
    assign sgn     = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign s_neg   = sgn && s[N-1];
    assign t_neg   = sgn && t[N-1];
    assign last    = (cnt == SHW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and handshake; DONE accepts like IDLE because HI/LO are already final.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE, DONE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                state_nx = IDLE;
                if (in_valid && is_mul)      state_nx = MUL;
                else if (in_valid && is_div) state_nx = DIV;
            end
            MUL: if (last) begin
                finish   = 1'b1;
                state_nx = DONE;
            end
            DIV: if (div_zero || last) begin
                finish   = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle result and signed overflow.
    always_comb begin
        sum    = s + t;
        dif    = s - t;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (alu_op)
            OP_SLL:  sc_res = t << shamt;
            OP_SRL:  sc_res = t >> shamt;
            OP_SRA:  sc_res = $signed(t) >>> shamt;
            OP_ADD:  begin sc_res = sum; sc_ovf = (s[N-1] == t[N-1]) && (sum[N-1] != s[N-1]); end
            OP_ADDU: sc_res = sum;
            OP_SUB:  begin sc_res = dif; sc_ovf = (s[N-1] != t[N-1]) && (dif[N-1] != s[N-1]); end
            OP_SUBU: sc_res = dif;
            OP_AND:  sc_res = s & t;
            OP_OR:   sc_res = s | t;
            OP_XOR:  sc_res = s ^ t;
            OP_NOR:  sc_res = ~(s | t);
            OP_SLT:  sc_res = {{(N-1){1'b0}}, $signed(s) < $signed(t)};
            OP_SLTU: sc_res = {{(N-1){1'b0}}, s < t};
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            default: sc_res = '0;
        endcase
    end

    // One shift-add or restoring-subtract step, plus sign fix-up of the final {hi,lo}.
    always_comb begin
        msum     = '0;
        rsh      = '0;
        rdiff    = '0;
        acc_step = acc;
        if (state == MUL) begin
            msum     = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_step = {msum, acc[N-1:1]};
        end else begin
            rsh   = {acc[2*N-1:N], acc[N-1]};
            rdiff = rsh - {1'b0, opnd};
            if (!rdiff[N]) acc_step = {rdiff[N-1:0], acc[N-2:0], 1'b1};
            else           acc_step = {rsh[N-1:0],   acc[N-2:0], 1'b0};
        end
        prod   = neg_q ? -acc_step : acc_step;
        fin_hi = prod[2*N-1:N];
        fin_lo = prod[N-1:0];
        if (state == DIV) begin
            if (div_zero) begin
                // The dividend magnitude sits untouched in the quotient half; undo its sign.
                fin_hi = cond_neg(neg_r, acc[N-1:0]);
                fin_lo = '1;
            end else begin
                fin_hi = cond_neg(neg_r, acc_step[2*N-1:N]);
                fin_lo = cond_neg(neg_q, acc_step[N-1:0]);
            end
        end
    end

    // Iteration operands: load magnitudes on accept, step once per MUL/DIV cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (accept && is_mul) begin
            acc   <= {{N{1'b0}}, cond_neg(t_neg, t)};
            opnd  <= cond_neg(s_neg, s);
            cnt   <= '0;
            neg_q <= s_neg ^ t_neg;
        end else if (accept && is_div) begin
            acc      <= {{N{1'b0}}, cond_neg(s_neg, s)};
            opnd     <= cond_neg(t_neg, t);
            cnt      <= '0;
            neg_q    <= s_neg ^ t_neg;
            neg_r    <= s_neg;
            div_zero <= (t == '0);
            div_ovf  <= sgn && (s == MIN_VAL) && (t == '1);
        end else if (state == MUL || state == DIV) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
        end
    end

    // HI/LO are written only when a multiply/divide completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= fin_hi;
            lo <= fin_lo;
        end
    end

    // Result registers; out/zero/overflow hold between out_valid pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (finish) begin
                out_valid <= 1'b1;
                out       <= fin_lo;
                zero      <= (fin_lo == '0) || (state == DIV && div_zero);
                overflow  <= (state == DIV) && div_ovf;
            end else if (accept && !is_mul && !is_div) begin
                out_valid <= 1'b1;
                out       <= sc_res;
                zero      <= (sc_res == '0);
                overflow  <= sc_ovf;
            end
        end
    end

    // Report illegal opcodes when simulated.
    always_ff @(posedge clk) begin
        if (!reset && accept && illegal) $warning("alu_seq: illegal alu_op %0d", alu_op);
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    alu_op;
    logic [N-1:0]  s, t;
    logic [4:0]    shamt;
    logic          out_valid;
    logic [N-1:0]  out;
    logic          zero, overflow;
    logic [N-1:0]  hi, lo;

    alu_seq #(.N(N), .SHW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .s(s), .t(t), .shamt(shamt), .out_valid(out_valid),
        .out(out), .zero(zero), .overflow(overflow), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [31:0] out;
        logic        zero;
        logic        ovf;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mhi = '0, mlo = '0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on 64-bit integers; also tracks HI/LO and latency.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t            e;
        longint          sa, sb, p;
        longint unsigned up;
        sa = $signed(a);
        sb = $signed(b);
        e.cyc = 1; e.out = '0; e.ovf = 1'b0;
        case (op)
            0:  e.out = b << sh;
            1:  e.out = b >> sh;
            2:  e.out = 32'($signed(b) >>> sh);
            3:  begin p = sa + sb; e.out = p[31:0]; e.ovf = (p != longint'($signed(p[31:0]))); end
            4:  e.out = a + b;
            5:  begin p = sa - sb; e.out = p[31:0]; e.ovf = (p != longint'($signed(p[31:0]))); end
            6:  e.out = a - b;
            7:  e.out = a & b;
            8:  e.out = a | b;
            9:  e.out = a ^ b;
            10: e.out = ~(a | b);
            11: e.out = (sa < sb) ? 32'd1 : 32'd0;
            12: e.out = (a < b) ? 32'd1 : 32'd0;
            13: begin p = sa * sb; {mhi, mlo} = p; e.cyc = 33; end
            14: begin up = {32'd0, a} * {32'd0, b}; {mhi, mlo} = up; e.cyc = 33; end
            15, 16: begin
                e.cyc = 33;
                if (b == 0) begin
                    mlo = '1; mhi = a; e.cyc = 2;
                end else if (op == 15) begin
                    p = sa / sb; mlo = p[31:0];
                    p = sa % sb; mhi = p[31:0];
                    e.ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                end else begin
                    mlo = a / b; mhi = a % b;
                end
            end
            17: e.out = mhi;
            18: e.out = mlo;
            default: e.out = '0;
        endcase
        if (op >= 13 && op <= 16) e.out = mlo;
        e.zero = (e.out == 0) || ((op == 15 || op == 16) && b == 0);
        e.hi = mhi;
        e.lo = mlo;
        return e;
    endfunction

    // Called at a negedge; waits for in_ready, presents one request, returns at the next negedge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; fails++;
            $display("FAIL issue_wait: in_ready stayed %b after %0d cycles, required 1", in_ready, n);
        end
        in_valid = 1'b1; alu_op = op; s = a; t = b; shamt = sh;
        e = model(op, a, b, sh);
        e.cyc = e.cyc + cyc;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sbq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_out_valid at cycle %0d: out=%h, required no pulse", cyc, out);
            end else begin
                e = sbq.pop_front();
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                chk("out", 64'(out), 64'(e.out));
                chk("zero", 64'(zero), 64'(e.zero));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            5:       return -32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; alu_op = '0; s = '0; t = '0; shamt = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_zero", 64'(zero), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        // Reset in the middle of a MULT aborts it without touching HI/LO.
        reset = 1'b0;
        in_valid = 1'b1; alu_op = 5'd13; s = 32'd123457; t = 32'd98765;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mult_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        chk("abort_hi_later", 64'(hi), 64'd0);
        chk("abort_lo_later", 64'(lo), 64'd0);

        // Signed overflow on ADD, none on ADDU.
        issue(5'd3, 32'h7FFF_FFFF, 32'd1, 5'd0);
        issue(5'd4, 32'h7FFF_FFFF, 32'd1, 5'd0);
        // Back-to-back shifts.
        issue(5'd0, 32'h0, 32'd1, 5'd31);
        issue(5'd2, 32'h0, 32'h8000_0000, 5'd4);

        // MULT -3*7: in_ready low for exactly 32 cycles.
        issue(5'd13, -32'd3, 32'd7, 5'd0);
        n = 0;
        while (!in_ready && n < 100) begin n++; @(negedge clk); end
        chk("mult_busy_cycles", 64'(n), 64'd32);
        issue(5'd14, 32'hFFFF_FFFF, 32'd2, 5'd0);

        // Divides: signed, divide-by-zero, MIN / -1.
        issue(5'd15, -32'd7, 32'd2, 5'd0);
        issue(5'd15, 32'd5, 32'd0, 5'd0);
        issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);

        // Requests presented during a DIV are ignored; MFHI then returns the remainder.
        issue(5'd15, 32'd100, 32'd7, 5'd0);
        in_valid = 1'b1; alu_op = 5'd3; s = 32'd1; t = 32'd2;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        issue(5'd17, 32'd0, 32'd0, 5'd0);
        issue(5'd18, 32'd0, 32'd0, 5'd0);

        // Illegal opcode yields zero.
        issue(5'd25, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);

        // Randomized mix.
        for (int i = 0; i < 150; i++) begin
            issue(5'($urandom_range(0, 18)), pick(), pick(), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        n = 0;
        while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
